// File: rtl/uart_tx_serializer_if.sv
// Write-side and serial-line bundle for uart_tx_serializer.
// When UART_TX_BREAK_EN is defined the bundle also carries i_break.
interface uart_tx_serializer_if;
   logic       i_tx_write_en;
   logic [7:0] i_tx_data;
   logic       o_tx_full;
   logic       o_tx_empty;
   logic       o_TX;
`ifdef UART_TX_BREAK_EN
   logic       i_break;

   modport master (output i_tx_write_en, output i_tx_data, output i_break,
                   input o_tx_full, input o_tx_empty, input o_TX);
   modport slave  (input i_tx_write_en, input i_tx_data, input i_break,
                   output o_tx_full, output o_tx_empty, output o_TX);
`else
   modport master (output i_tx_write_en, output i_tx_data,
                   input o_tx_full, input o_tx_empty, input o_TX);
   modport slave  (input i_tx_write_en, input i_tx_data,
                   output o_tx_full, output o_tx_empty, output o_TX);
`endif
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: holding register + shift register, start/data/parity/stop framing.
// Optional line-break control is compiled in with the UART_TX_BREAK_EN macro.
module uart_tx_serializer #(
   parameter int CLK_FREQ_HZ = 10000000,
   parameter int BAUDRATE    = 38400,
   parameter int DATA_BITS   = 8,
   parameter int USE_PARITY  = 0,
   parameter int ODD_PARITY  = 0
) (
   input  logic                 clk_cpu,
   input  logic                 rst_cpu,
   uart_tx_serializer_if.slave  bus
);
   localparam int BAUD_DIV = CLK_FREQ_HZ / BAUDRATE;
   localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

   generate
      if (BAUD_DIV < 2) begin : g_baud_chk
         $error("uart_tx_serializer: CLK_FREQ_HZ/BAUDRATE must be at least 2");
      end
      if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_bits_chk
         $error("uart_tx_serializer: DATA_BITS must be 5..8");
      end
   endgenerate

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5,
      ST_MARK   = 3'd6
   } state_t;

   state_t               state_r,      state_nxt_s;
   logic [CNT_W-1:0]     cnt_r,        cnt_nxt_s;
   logic [2:0]           idx_r,        idx_nxt_s;
   logic [DATA_BITS-1:0] shift_r,      shift_nxt_s;
   logic [DATA_BITS-1:0] hold_r,       hold_nxt_s;
   logic                 hold_valid_r, hold_valid_nxt_s;
   logic                 par_r,        par_nxt_s;
   logic                 tx_r,         tx_nxt_s;
   logic                 full_r;
   logic                 empty_r;
   logic                 bit_end_s;
   logic                 load_s;
   logic                 brk_s;

   function automatic logic parity_f(input logic [DATA_BITS-1:0] data);
      parity_f = (^data) ^ (ODD_PARITY != 0);
   endfunction

`ifdef UART_TX_BREAK_EN
   assign brk_s = bus.i_break;
`else
   assign brk_s = 1'b0;
`endif

   // Next-state, datapath and line-level computation for the framing FSM
   always_comb begin
      state_nxt_s      = state_r;
      cnt_nxt_s        = cnt_r;
      idx_nxt_s        = idx_r;
      shift_nxt_s      = shift_r;
      hold_nxt_s       = hold_r;
      hold_valid_nxt_s = hold_valid_r;
      par_nxt_s        = par_r;
      tx_nxt_s         = 1'b1;
      load_s           = 1'b0;
      bit_end_s        = (cnt_r == CNT_W'(BAUD_DIV - 1));

      if (bus.i_tx_write_en && !hold_valid_r) begin
         hold_nxt_s       = bus.i_tx_data[DATA_BITS-1:0];
         hold_valid_nxt_s = 1'b1;
      end else begin
         hold_nxt_s       = hold_r;
      end

      case (state_r)
         ST_IDLE: begin
            cnt_nxt_s = '0;
            if (brk_s) begin
               state_nxt_s = ST_BREAK;
            end else if (hold_valid_r) begin
               load_s = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_START: begin
            cnt_nxt_s = bit_end_s ? '0 : cnt_r + CNT_W'(1);
            if (bit_end_s) begin
               state_nxt_s = ST_DATA;
               idx_nxt_s   = 3'd0;
            end else begin
               state_nxt_s = ST_START;
            end
         end
         ST_DATA: begin
            cnt_nxt_s = bit_end_s ? '0 : cnt_r + CNT_W'(1);
            if (bit_end_s && (idx_r == 3'(DATA_BITS - 1))) begin
               state_nxt_s = (USE_PARITY != 0) ? ST_PARITY : ST_STOP;
            end else if (bit_end_s) begin
               idx_nxt_s   = idx_r + 3'd1;
               shift_nxt_s = shift_r >> 1;
            end else begin
               state_nxt_s = ST_DATA;
            end
         end
         ST_PARITY: begin
            cnt_nxt_s = bit_end_s ? '0 : cnt_r + CNT_W'(1);
            if (bit_end_s) begin
               state_nxt_s = ST_STOP;
            end else begin
               state_nxt_s = ST_PARITY;
            end
         end
         ST_STOP: begin
            cnt_nxt_s = bit_end_s ? '0 : cnt_r + CNT_W'(1);
            if (bit_end_s && brk_s) begin
               state_nxt_s = ST_BREAK;
            end else if (bit_end_s && hold_valid_r) begin
               load_s = 1'b1;
            end else if (bit_end_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_STOP;
            end
         end
         ST_BREAK: begin
            cnt_nxt_s = '0;
            if (brk_s) begin
               state_nxt_s = ST_BREAK;
            end else begin
               state_nxt_s = ST_MARK;
            end
         end
         ST_MARK: begin
            // Guaranteed one full bit of mark after a break before any frame
            cnt_nxt_s = bit_end_s ? '0 : cnt_r + CNT_W'(1);
            if (brk_s) begin
               state_nxt_s = ST_BREAK;
               cnt_nxt_s   = '0;
            end else if (bit_end_s && hold_valid_r) begin
               load_s = 1'b1;
            end else if (bit_end_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_MARK;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = '0;
         end
      endcase

      if (load_s) begin
         state_nxt_s      = ST_START;
         cnt_nxt_s        = '0;
         idx_nxt_s        = 3'd0;
         shift_nxt_s      = hold_r;
         par_nxt_s        = parity_f(hold_r);
         hold_valid_nxt_s = 1'b0;
      end else begin
         par_nxt_s        = par_r;
      end

      case (state_nxt_s)
         ST_START:  tx_nxt_s = 1'b0;
         ST_BREAK:  tx_nxt_s = 1'b0;
         ST_DATA:   tx_nxt_s = shift_nxt_s[0];
         ST_PARITY: tx_nxt_s = par_nxt_s;
         default:   tx_nxt_s = 1'b1;
      endcase
   end

   // State, datapath and registered outputs with synchronous reset
   always_ff @(posedge clk_cpu) begin
      if (rst_cpu) begin
         state_r      <= ST_IDLE;
         cnt_r        <= '0;
         idx_r        <= 3'd0;
         shift_r      <= '0;
         hold_r       <= '0;
         hold_valid_r <= 1'b0;
         par_r        <= 1'b0;
         tx_r         <= 1'b1;
         full_r       <= 1'b0;
         empty_r      <= 1'b1;
      end else begin
         state_r      <= state_nxt_s;
         cnt_r        <= cnt_nxt_s;
         idx_r        <= idx_nxt_s;
         shift_r      <= shift_nxt_s;
         hold_r       <= hold_nxt_s;
         hold_valid_r <= hold_valid_nxt_s;
         par_r        <= par_nxt_s;
         tx_r         <= tx_nxt_s;
         full_r       <= hold_valid_nxt_s;
         empty_r      <= !hold_valid_nxt_s && (state_nxt_s == ST_IDLE);
      end
   end

   assign bus.o_TX       = tx_r;
   assign bus.o_tx_full  = full_r;
   assign bus.o_tx_empty = empty_r;

endmodule
